instruction_sequencer: RTL
==========================

# instruction_sequencer

Program sequencer for the Aeolus control path: holds a small loadable program of 4-bit opcodes and issues them, one per qualified cycle, to the instruction decoder's opcode input. It is the producing end of the opcode interface. It emits registered opcode/valid pairs in program order, with run, pause, single-step and end-of-program control. It sits between the host/loader and the decoder, and is paced by a tick from the clock divider.

## Interface
Parameters:
- ADDR_WIDTH, 4, program address width; depth = 2^ADDR_WIDTH words.
- OPCODE_WIDTH, 4, opcode width; must match the decoder input.

Ports:
- CLKin  in  1  system clock; all state changes on the rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- TICK  in  1  issue qualifier (clock-divider tap, or tie 1); gates RUN-mode issues only.
- LOADen  in  1  program write strobe.
- LOADaddr  in  ADDR_WIDTH  program write address.
- LOADdata  in  OPCODE_WIDTH  program write data.
- progLast  in  ADDR_WIDTH  address of the last instruction; sampled on RUN or STEP from IDLE/DONE.
- RUN  in  1  start or resume continuous execution.
- STEP  in  1  issue exactly one instruction.
- HALT  in  1  pause continuous execution.
- instructionOut  out  OPCODE_WIDTH  opcode being issued (registered).
- instrValid  out  1  high for exactly one cycle per issued opcode.
- PCout  out  ADDR_WIDTH  address of the next instruction to issue.
- BUSY  out  1  high while in RUN.
- DONE  out  1  high in the DONE state.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Priority of requests on the same edge: HALT > RUN > STEP.
- Program memory is 2^ADDR_WIDTH x OPCODE_WIDTH with synchronous write and combinational read.
  - A write occurs only when LOADen=1 in IDLE, PAUSE or DONE. LOADen in RUN is ignored.
  - Memory contents are not reset.
- IDLE:
  - RUN: PC<=0, latch progLast into lastReg, go to RUN.
  - STEP: PC<=0, latch progLast, issue mem[0], go to PAUSE; go to DONE instead if lastReg=0.
- RUN, on each edge with TICK=1 and HALT=0:
  - Issue mem[PC] (instructionOut<=mem[PC], instrValid<=1).
  - If PC==lastReg, go to DONE and leave PC unchanged. Otherwise PC<=PC+1.
  - TICK=0: no issue, instrValid<=0, state held.
- RUN with HALT=1: no issue; go to PAUSE regardless of TICK.
- PAUSE:
  - RUN: go to RUN without reloading PC or lastReg.
  - STEP: issue mem[PC] and advance as in RUN; go to DONE if PC==lastReg.
  - HALT: hold.
- DONE:
  - RUN: PC<=0, re-latch progLast, go to RUN.
  - STEP: restart single-step at address 0, as from IDLE.
  - HALT: no effect.
- PC never wraps. progLast = 2^ADDR_WIDTH-1 issues the full memory and then enters DONE.
- instructionOut holds the last issued opcode between issues. Only instrValid marks new ones.

## Timing
- Reset values: instructionOut=0, instrValid=0, PCout=0, BUSY=0, DONE=0, state IDLE, lastReg=0.
- RSTn low mid-run: outputs go to reset values immediately, with no partial issue. Memory is retained.
- Latency, RUN sampled at edge k from IDLE:
  - Edge k+1 is the first issue, if TICK=1 then.
  - mem[0] is visible with instrValid=1 during cycle k+1 to k+2.
- STEP latency: the opcode is visible in the cycle after the edge that sampled STEP.
- Throughput: with TICK tied high, one opcode per cycle.
- BUSY and DONE are registered state decodes; they update on the same edge as the state.
- A program write at edge k is readable by an issue at edge k+1 or later.

## Structure
- Shared package aeolus_ctrl_pkg holds:
  - the state encoding (2-bit enum);
  - opcode constants LDA=0, LDB=1, LDO=2, LDSA=3, LDSB=4, LSH=5, RSH=6, CLR=7, SNZA=8, SNZS=9, ADD=10, SUB=11, AND=12, OR=13, XOR=14, INV=15;
  - default ADDR_WIDTH and OPCODE_WIDTH.
- Sub-module: program_mem, the write-port register array with combinational read. The FSM and PC stay in instruction_sequencer.

## Test plan
- Reset mid-RUN: drop RSTn while issuing -> all outputs 0 asynchronously; state IDLE after release; memory unchanged.
- Load mem[0..3]=LDA,LDB,ADD,LDO (0,1,10,2), progLast=3, TICK=1, pulse RUN -> four consecutive instrValid pulses carrying 0,1,10,2; then DONE=1, BUSY=0, PCout=3.
- Same program with TICK high every 4th cycle -> issues occur only on tick edges; order and count unchanged.
- HALT asserted after the second issue, with RUN also asserted on the same edge -> no third issue, state PAUSE; a later RUN resumes and issues 10,2.
- From IDLE, three STEP pulses with progLast=1 -> issues 0 then 1, then DONE; the third STEP restarts and issues 0.
- LOADen in RUN writing mem[2]=15 -> ignored; opcode 10 is still issued at address 2.
- progLast=15 with a full 16-word load -> 16 issues, no wrap, DONE.

Source files
------------

// File: rtl/aeolus_ctrl_pkg.sv
// Shared definitions for the Aeolus control path: sequencer state encoding,
// decoder opcode values and default widths.
package aeolus_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_OPCODE_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [3:0] LDA  = 4'd0;
    localparam logic [3:0] LDB  = 4'd1;
    localparam logic [3:0] LDO  = 4'd2;
    localparam logic [3:0] LDSA = 4'd3;
    localparam logic [3:0] LDSB = 4'd4;
    localparam logic [3:0] LSH  = 4'd5;
    localparam logic [3:0] RSH  = 4'd6;
    localparam logic [3:0] CLR  = 4'd7;
    localparam logic [3:0] SNZA = 4'd8;
    localparam logic [3:0] SNZS = 4'd9;
    localparam logic [3:0] ADD  = 4'd10;
    localparam logic [3:0] SUB  = 4'd11;
    localparam logic [3:0] AND  = 4'd12;
    localparam logic [3:0] OR   = 4'd13;
    localparam logic [3:0] XOR  = 4'd14;
    localparam logic [3:0] INV  = 4'd15;

endpackage

// File: rtl/program_mem.sv
// Program store: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset so a program
// survives a sequencer reset.
module program_mem
    import aeolus_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: a word written on one edge is readable from the next cycle on.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_sequencer.sv
// Program sequencer: issues stored opcodes in program order to the decoder,
// with run / pause / single-step / end-of-program control paced by TICK.
module instruction_sequencer
    import aeolus_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic                    CLKin,
    input  logic                    RSTn,
    input  logic                    TICK,
    input  logic                    LOADen,
    input  logic [ADDR_WIDTH-1:0]   LOADaddr,
    input  logic [OPCODE_WIDTH-1:0] LOADdata,
    input  logic [ADDR_WIDTH-1:0]   progLast,
    input  logic                    RUN,
    input  logic                    STEP,
    input  logic                    HALT,
    output logic [OPCODE_WIDTH-1:0] instructionOut,
    output logic                    instrValid,
    output logic [ADDR_WIDTH-1:0]   PCout,
    output logic                    BUSY,
    output logic                    DONE
);

    seq_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   last_q, last_d;
    logic [OPCODE_WIDTH-1:0] instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [OPCODE_WIDTH-1:0] rd_data;
    logic                    restart;

    // A step from IDLE/DONE always restarts at address 0; otherwise read at PC.
    assign restart = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign rd_addr = restart ? '0 : pc_q;
    assign mem_we  = LOADen && (state_q != ST_RUN);

    program_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (OPCODE_WIDTH)
    ) u_program_mem (
        .clk_i   (CLKin),
        .we_i    (mem_we),
        .waddr_i (LOADaddr),
        .wdata_i (LOADdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Next-state logic; HALT masks RUN and STEP in every state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!HALT) begin
                    if (RUN) begin
                        pc_d    = '0;
                        last_d  = progLast;
                        state_d = ST_RUN;
                    end else if (STEP) begin
                        last_d  = progLast;
                        instr_d = rd_data;
                        valid_d = 1'b1;
                        if (progLast == '0) begin
                            pc_d    = '0;
                            state_d = ST_DONE;
                        end else begin
                            pc_d    = ADDR_WIDTH'(1);
                            state_d = ST_PAUSE;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (HALT) begin
                    state_d = ST_PAUSE;
                end else if (TICK) begin
                    instr_d = rd_data;
                    valid_d = 1'b1;
                    if (pc_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (!HALT) begin
                    if (RUN) begin
                        state_d = ST_RUN;
                    end else if (STEP) begin
                        instr_d = rd_data;
                        valid_d = 1'b1;
                        if (pc_q == last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            pc_d = pc_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, PC and registered outputs; reset clears everything but memory.
    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instructionOut = instr_q;
    assign instrValid     = valid_q;
    assign PCout          = pc_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;

endmodule
